// File: rtl/m65c02_int_stim_pkg.sv
// rtl/m65c02_int_stim_pkg.sv - shared encodings for the M65C02 interrupt/stimulus generator
package m65c02_int_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ASSERT = 2'd2
    } chan_state_e;

    typedef enum logic [1:0] {
        MODE_LEVEL    = 2'b00,
        MODE_PULSE    = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DLY_LO = 2'd1;
    localparam logic [1:0] REG_DLY_HI = 2'd2;
    localparam logic [1:0] REG_PW     = 2'd3;

    localparam int CTRL_ARM_BIT      = 0;
    localparam int CTRL_CLR_BIT      = 1;
    localparam int CTRL_MODE_LSB     = 2;
    localparam int CTRL_STATE_LSB    = 4;
    localparam int CTRL_ASSERTED_BIT = 7;

    // Reserved mode folds to LEVEL; PERIODIC folds to PULSE when that feature is absent.
    function automatic mode_e norm_mode(input logic [1:0] m, input logic periodic_en);
        case (m)
            2'b11:   return MODE_LEVEL;
            2'b10:   return periodic_en ? MODE_PERIODIC : MODE_PULSE;
            default: return mode_e'(m);
        endcase
    endfunction

endpackage

// File: rtl/m65c02_int_chan.sv
// rtl/m65c02_int_chan.sv - one channel: registers, FSM, delay and pulse-width counters
// Optional PERIODIC reload is built only with M65C02_INT_STIM_PERIODIC_EN defined.
module m65c02_int_chan
    import m65c02_int_stim_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wr_en,
    input  logic [1:0] reg_sel,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       n_int,
    output logic       busy
);

`ifdef M65C02_INT_STIM_PERIODIC_EN
    localparam logic PERIODIC_EN = 1'b1;
`else
    localparam logic PERIODIC_EN = 1'b0;
`endif

    chan_state_e state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [15:0] dly_q, dly_d, cnt_q, cnt_d;
    logic [7:0]  pw_q, pw_d, pwcnt_q, pwcnt_d;
    logic        n_int_q, n_int_d;
    logic        arm, clr;
    logic [7:0]  pw_load;

    assign pw_load = (pw_q == 8'd0) ? 8'd1 : pw_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dly_d   = dly_q;
        pw_d    = pw_q;
        cnt_d   = cnt_q;
        pwcnt_d = pwcnt_q;
        arm     = 1'b0;
        clr     = 1'b0;

        if (wr_en) begin
            case (reg_sel)
                REG_CTRL: begin
                    mode_d = norm_mode(wdata[CTRL_MODE_LSB +: 2], PERIODIC_EN);
                    arm    = wdata[CTRL_ARM_BIT];
                    clr    = wdata[CTRL_CLR_BIT];
                end
                REG_DLY_LO: dly_d[7:0]  = wdata;
                REG_DLY_HI: dly_d[15:8] = wdata;
                default:    pw_d        = wdata;
            endcase
        end

        // Counters load from the stored DLY/PW, so rewrites only matter at the next load.
        if (clr) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            if (dly_q == 16'd0) begin
                state_d = ST_ASSERT;
                pwcnt_d = pw_load;
            end else begin
                state_d = ST_COUNT;
                cnt_d   = dly_q;
            end
        end else if (ce) begin
            case (state_q)
                ST_COUNT: begin
                    if (cnt_q == 16'd1) begin
                        state_d = ST_ASSERT;
                        pwcnt_d = pw_load;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_ASSERT: begin
                    if (pwcnt_q > 8'd1) begin
                        pwcnt_d = pwcnt_q - 8'd1;
                    end else if (mode_d == MODE_PULSE) begin
                        state_d = ST_IDLE;
`ifdef M65C02_INT_STIM_PERIODIC_EN
                    end else if (mode_d == MODE_PERIODIC) begin
                        if (dly_q == 16'd0) begin
                            pwcnt_d = pw_load;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = dly_q;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end

        n_int_d = (state_d != ST_ASSERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LEVEL;
            dly_q   <= 16'd0;
            pw_q    <= 8'd0;
            cnt_q   <= 16'd0;
            pwcnt_q <= 8'd0;
            n_int_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dly_q   <= dly_d;
            pw_q    <= pw_d;
            cnt_q   <= cnt_d;
            pwcnt_q <= pwcnt_d;
            n_int_q <= n_int_d;
        end
    end

    always_comb begin
        rdata = 8'd0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_ASSERTED_BIT]     = ~n_int_q;
                rdata[CTRL_STATE_LSB +: 2]   = state_q;
                rdata[CTRL_MODE_LSB +: 2]    = mode_q;
            end
            REG_DLY_LO: rdata = dly_q[7:0];
            REG_DLY_HI: rdata = dly_q[15:8];
            default:    rdata = pw_q;
        endcase
    end

    assign n_int = n_int_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: rtl/m65c02_int_stim.sv
// rtl/m65c02_int_stim.sv - memory-mapped multi-channel interrupt/stimulus generator top
// Optional feature macro: M65C02_INT_STIM_PERIODIC_EN (PERIODIC channel mode).
module m65c02_int_stim
    import m65c02_int_stim_pkg::*;
#(
    parameter int          pChannels = 3,
    parameter logic [15:0] pBaseAddr = 16'hFFF0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 CE,
    input  logic                 WE,
    input  logic                 RE,
    input  logic [15:0]          A,
    input  logic [7:0]           DI,
    output logic [7:0]           DO,
    output logic [pChannels-1:0] nInt,
    output logic                 Busy
);

    logic                 sel;
    logic [1:0]           ch_idx;
    logic [pChannels-1:0] busy_vec;
    logic [7:0]           rdata [pChannels];

    assign sel    = (A[15:4] == pBaseAddr[15:4]);
    assign ch_idx = A[3:2];

    for (genvar g = 0; g < pChannels; g++) begin : g_chan
        m65c02_int_chan u_chan (
            .clk     (Clk),
            .rst     (Rst),
            .ce      (CE),
            .wr_en   (WE && sel && (ch_idx == 2'(g))),
            .reg_sel (A[1:0]),
            .wdata   (DI),
            .rdata   (rdata[g]),
            .n_int   (nInt[g]),
            .busy    (busy_vec[g])
        );
    end

    // Only instantiated channels appear in the mux, so unmapped slots read as 0.
    always_comb begin
        DO = 8'd0;
        if (sel && RE) begin
            for (int i = 0; i < pChannels; i++) begin
                if (ch_idx == i[1:0]) DO = rdata[i];
            end
        end
    end

    assign Busy = |busy_vec;

endmodule

// File: tb/tb_m65c02_int_stim.sv
// tb/tb_m65c02_int_stim.sv - directed self-checking bench for m65c02_int_stim
module tb_m65c02_int_stim;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        CE  = 1'b1;
    logic        WE  = 1'b0;
    logic        RE  = 1'b0;
    logic [15:0] A   = 16'h0000;
    logic [7:0]  DI  = 8'h00;
    logic [7:0]  DO;
    logic [2:0]  nInt;
    logic        Busy;

    int vectors     = 0;
    int miscompares = 0;

    m65c02_int_stim #(.pChannels(3), .pBaseAddr(16'hFFF0)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .CE   (CE),
        .WE   (WE),
        .RE   (RE),
        .A    (A),
        .DI   (DI),
        .DO   (DO),
        .nInt (nInt),
        .Busy (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge Clk);
        A  = addr;
        DI = data;
        WE = 1'b1;
        @(posedge Clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [7:0] data);
        A  = addr;
        RE = 1'b1;
        #1;
        data = DO;
        RE = 1'b0;
    endtask

    task automatic edge1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rv;
        logic [39:0] trace_obs, trace_exp;
        int          first, lowcnt;

        // Reset state, then reset asynchronously in the middle of a countdown
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        chk("reset_nint", nInt, 3'b111);
        chk("reset_busy", Busy, 1'b0);
        wr(16'hFFF1, 8'd100);
        wr(16'hFFF0, 8'h01);
        repeat (50) edge1();
        chk("count_busy", Busy, 1'b1);
        chk("count_nint", nInt, 3'b111);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_nint", nInt, 3'b111);
        chk("async_rst_busy", Busy, 1'b0);
        rd(16'hFFF0, rv); chk("async_rst_ctrl", rv, 8'h00);
        rd(16'hFFF1, rv); chk("async_rst_dly", rv, 8'h00);
        @(negedge Clk);
        Rst = 1'b0;

        // ch0 LEVEL, DLY=5
        wr(16'hFFF1, 8'd5);
        wr(16'hFFF0, 8'h01);
        chk("lvl_t0", nInt[0], 1'b1);
        repeat (4) edge1();
        chk("lvl_t4", nInt[0], 1'b1);
        edge1();
        chk("lvl_t5", nInt[0], 1'b0);
        rd(16'hFFF0, rv); chk("lvl_ctrl_assert", rv, 8'hA0);
        repeat (1000) edge1();
        chk("lvl_hold", nInt[0], 1'b0);
        wr(16'hFFF0, 8'h02);
        chk("lvl_clr", nInt[0], 1'b1);
        rd(16'hFFF0, rv); chk("lvl_ctrl_clr", rv, 8'h00);

        // ch1 PULSE, DLY=0, PW=3 then PW=0
        wr(16'hFFF7, 8'd3);
        wr(16'hFFF4, 8'h05);
        lowcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (nInt[1] == 1'b0) lowcnt++;
            edge1();
        end
        chk("pulse_pw3", lowcnt, 3);
        wr(16'hFFF7, 8'd0);
        wr(16'hFFF4, 8'h05);
        lowcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (nInt[1] == 1'b0) lowcnt++;
            edge1();
        end
        chk("pulse_pw0", lowcnt, 1);
        chk("pulse_idle_busy", Busy, 1'b0);

        // ch2 PULSE, DLY=4, CE toggling
        wr(16'hFFF9, 8'd4);
        wr(16'hFFFB, 8'd2);
        wr(16'hFFF8, 8'h05);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            CE = (k % 2 == 0);
            edge1();
            if (first == 0 && nInt[2] == 1'b0) first = k;
        end
        chk("ce_toggle_first", first, 8);
        chk("ce_freeze_low", nInt[2], 1'b0);
        CE = 1'b1;
        repeat (3) edge1();
        chk("ce_toggle_done", Busy, 1'b0);

        // ch1 PERIODIC (or PULSE fallback), DLY=10, PW=2
        wr(16'hFFF5, 8'd10);
        wr(16'hFFF7, 8'd2);
        wr(16'hFFF4, 8'h09);
        rd(16'hFFF4, rv);
`ifdef M65C02_INT_STIM_PERIODIC_EN
        chk("periodic_ctrl", rv, 8'h18);
`else
        chk("periodic_ctrl", rv, 8'h14);
`endif
        for (int k = 1; k <= 40; k++) begin
            edge1();
            trace_obs[k-1] = nInt[1];
`ifdef M65C02_INT_STIM_PERIODIC_EN
            trace_exp[k-1] = !(k >= 10 && ((k - 10) % 12) < 2);
`else
            trace_exp[k-1] = !(k == 10 || k == 11);
`endif
        end
        chk("periodic_trace", trace_obs, trace_exp);
        wr(16'hFFF4, 8'h02);
        chk("periodic_clr_busy", Busy, 1'b0);

        // Unmapped channel, read gating, decode
        wr(16'hFFFC, 8'h01);
        wr(16'hFFFD, 8'h55);
        rd(16'hFFFD, rv); chk("unmapped_dly", rv, 8'h00);
        rd(16'hFFFC, rv); chk("unmapped_ctrl", rv, 8'h00);
        chk("unmapped_busy", Busy, 1'b0);
        chk("unmapped_nint", nInt, 3'b111);
        A = 16'hFFF5; RE = 1'b0; #1;
        chk("re_low", DO, 8'h00);
        rd(16'hFFF5, rv); chk("re_high", rv, 8'h0A);
        rd(16'h1235, rv); chk("not_selected", rv, 8'h00);
        wr(16'hFFF2, 8'hAB);
        rd(16'hFFF2, rv); chk("dly_hi_rw", rv, 8'hAB);
        wr(16'hFFF2, 8'h00);

        // CLR and ARM together: CLR wins
        wr(16'hFFF1, 8'd0);
        wr(16'hFFF0, 8'h03);
        chk("clr_arm_nint", nInt[0], 1'b1);
        chk("clr_arm_busy", Busy, 1'b0);

        // DLY rewrite during COUNT does not disturb the countdown
        wr(16'hFFF1, 8'd6);
        wr(16'hFFF0, 8'h01);
        wr(16'hFFF1, 8'd20);
        first = 0;
        for (int k = 2; k <= 12; k++) begin
            edge1();
            if (first == 0 && nInt[0] == 1'b0) first = k;
        end
        chk("dly_rewrite_first", first, 6);
        rd(16'hFFF1, rv); chk("dly_rewrite_read", rv, 8'd20);
        wr(16'hFFF0, 8'h02);
        chk("final_nint", nInt, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m65c02_int_stim.md
# m65c02_int_stim

Memory-mapped, multi-channel interrupt/stimulus generator for the M65C02 core. It generalises the fixed "write 0xFFF8 asserts nIRQ, write 0xFFF9 releases" scheme to N independent channels: each has a programmable delay, pulse width and mode, driving active-low nIRQ/nNMI/nSO-style outputs. It sits on the processor bus beside RAM/ROM, so test programs can schedule their own interrupts deterministically. It is also usable as a synthesizable timer-interrupt source on the FPGA.

## Interface
- pChannels, 3, number of channels, 1..4.
- pBaseAddr, 16'hFFF0, base of the 16-byte register window; bits [3:0] are ignored.
- Clk  in  1  single clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- CE  in  1  count enable (e.g. one per bus cycle); gates delay and pulse counters only.
- WE  in  1  write strobe, sampled on Clk.
- RE  in  1  read enable for DO.
- A  in  16  bus address.
- DI  in  8  write data.
- DO  out  8  read data; combinational; 0 when not selected, not RE, or unmapped.
- nInt  out  pChannels  registered active-low interrupt outputs; bit i belongs to channel i.
- Busy  out  1  OR over channels of (state != IDLE).

## Operation
- Select: A[15:4] == pBaseAddr[15:4]. Channel = A[3:2]. Register = A[1:0].
  - Channels >= pChannels: writes are ignored and reads return 0.
- Per-channel registers:
  - +0 CTRL.
    - Write bit0 ARM (strobe), bit1 CLR (strobe), bits[3:2] MODE (stored).
    - Read bits[3:2] MODE, bits[5:4] state, bit7 = asserted (~nInt[i]). Other bits read 0.
  - +1 DLY_LO and +2 DLY_HI: 16-bit delay, read/write.
  - +3 PW: 8-bit pulse width, read/write; PW=0 behaves as 1.
- MODE encoding: 00 LEVEL, 01 PULSE, 10 PERIODIC, 11 reserved (treated and read back as LEVEL).
- Per-channel FSM with states IDLE=0, COUNT=1, ASSERT=2:
  - IDLE + ARM:
    - DLY=0 -> ASSERT.
    - DLY>0 -> COUNT, cnt=DLY.
  - COUNT: cnt decrements on CE. cnt==1 with CE -> ASSERT.
  - Entering ASSERT loads pwcnt=max(PW,1).
  - ASSERT, LEVEL: holds until CLR.
  - ASSERT, PULSE: pwcnt decrements on CE. pwcnt==1 with CE -> IDLE.
  - ASSERT, PERIODIC: same exit condition, but reload cnt from DLY -> COUNT (DLY=0 -> stay ASSERT with pwcnt reloaded).
  - CLR in any state -> IDLE. CLR and ARM in the same write: CLR wins.
  - ARM while COUNT/ASSERT restarts from the current DLY/PW (retrigger).
- DLY/PW writes during COUNT/ASSERT do not affect the running counters; they take effect at the next load.
- MODE writes take effect immediately, including the exit decision in ASSERT.
- nInt[i] is 0 exactly while state==ASSERT.

## Timing
- Reset: all states IDLE; CTRL/DLY/PW = 0; nInt all 1s; Busy 0. Applies asynchronously, including mid-count or mid-pulse.
- Write at edge t0, CE=1 continuously:
  - ARM with DLY=N>0: nInt falls after edge t0+N.
  - DLY=0: nInt falls after edge t0.
  - PULSE: nInt stays low for max(PW,1) clocks.
- CE low freezes both counters; the state is held.
- Counters are 16-bit and 8-bit. No wrap: the terminal condition is the 1->transition, never decrement past 1.
- CLR: nInt returns to 1 after the write edge; no extra latency.
- DO is combinational from A/RE with zero latency; reads have no side effects.

## Configuration
- M65C02_INT_STIM_PERIODIC_EN defined: MODE 10 behaves as PERIODIC as above.
- Not defined: a write of MODE 10 is stored and read back as 01 (PULSE); the reload logic is not generated.

## Structure
- Package m65c02_int_stim_pkg holds:
  - state encodings (IDLE/COUNT/ASSERT);
  - MODE encodings;
  - register offsets (CTRL=0, DLY_LO=1, DLY_HI=2, PW=3);
  - CTRL bit positions.
- Sub-module m65c02_int_chan: one channel's registers, FSM and counters.
  - The top generates pChannels instances plus address decode, DO mux and Busy.

## Test plan
- Reset mid-COUNT (DLY=100, Rst at cycle 50) -> nInt=3'b111, Busy=0, CTRL/DLY read 0 on ch0 (0xFFF0/0xFFF1).
- ch0 LEVEL, DLY=5, ARM at t0, CE=1 -> nInt[0] low after t0+5; stays low 1000 cycles; CLR write -> high next edge; CTRL read bit7=0.
- ch1 PULSE, DLY=0, PW=3 -> nInt[1] low for exactly 3 clocks after the write edge. Repeat with PW=0 -> low for exactly 1 clock.
- ch2 PULSE, DLY=4, CE toggling 1,0 -> assertion after edge t0+8.
- PERIODIC, DLY=10, PW=2 with macro defined -> low 2, high 10, repeating; without macro, CTRL MODE reads 01 and a single pulse occurs.
- Unmapped channel and simultaneous ops:
  - Write to 0xFFFC with pChannels=3 -> no effect, read 0.
  - Write CTRL=8'h03 -> channel stays IDLE.
  - DLY rewritten during COUNT -> current countdown unchanged.
